// File: rtl/branch_sequencer.sv
// branch_sequencer
//   Control-step sequencer for the Mini-SRC datapath covering fetch plus the
//   execute steps of conditional branch (br) and jump-register (jr).
//
// Ports
//   clk        : system clock, rising edge
//   clear      : asynchronous active-low reset
//   start      : begin one instruction (accepted only in IDLE)
//   mem_ready  : memory read data valid (looked at only during T1)
//   ir_opcode  : IR[31:27], valid from T3 onward
//   con_out    : CON FF output
//   pc_out .. add : one-bit datapath control strobes
//   busy       : high from start acceptance through the done cycle
//   done       : one-cycle completion pulse
//   taken      : PC was loaded with the branch/jump target (valid with done)
//   err        : 00 ok, 01 illegal opcode, 10 memory timeout
module branch_sequencer #(
  parameter logic [4:0]  BR_OPCODE   = 5'b10010,
  parameter logic [4:0]  JR_OPCODE   = 5'b10100,
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic       mem_ready,
  input  logic [4:0] ir_opcode,
  input  logic       con_out,
  output logic       pc_out,
  output logic       mar_in,
  output logic       inc_pc,
  output logic       z_in,
  output logic       zlow_out,
  output logic       pc_in,
  output logic       read,
  output logic       mdata_in,
  output logic       mdr_in,
  output logic       mdr_out,
  output logic       ir_in,
  output logic       gra,
  output logic       rout,
  output logic       con_in,
  output logic       y_in,
  output logic       c_out,
  output logic       add,
  output logic       busy,
  output logic       done,
  output logic       taken,
  output logic [1:0] err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_DONE,
    S_DONE_J,
    S_FAULT
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  state_t     next_state;
  logic [7:0] wait_cnt;

  // State register
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state <= S_IDLE;
    else        state <= next_state;
  end

  // T1 wait counter: zero outside T1, so it is zero on every T1 entry; saturates.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      wait_cnt <= '0;
    end else if (state != S_T1) begin
      wait_cnt <= '0;
    end else if (wait_cnt != '1) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Result flags: cleared on acceptance, written on the edge leaving the
  // deciding state so they are stable for the whole done cycle.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      err   <= '0;
      taken <= 1'b0;
    end else if (state == S_IDLE && start) begin
      err   <= '0;
      taken <= 1'b0;
    end else if (next_state == S_FAULT) begin
      err   <= (state == S_T1) ? 2'b10 : 2'b01;
      taken <= 1'b0;
    end else if (next_state == S_DONE_J) begin
      taken <= 1'b1;
    end else if (state == S_T6) begin
      taken <= con_out;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: if (start) next_state = S_T0;
      S_T0:   next_state = S_T1;
      S_T1: begin
        if (mem_ready)                     next_state = S_T2;
        else if (wait_cnt >= TIMEOUT_LAST) next_state = S_FAULT;
      end
      S_T2: next_state = S_T3;
      S_T3: begin
        if (ir_opcode == BR_OPCODE)      next_state = S_T4;
        else if (ir_opcode == JR_OPCODE) next_state = S_DONE_J;
        else                             next_state = S_FAULT;
      end
      S_T4:    next_state = S_T5;
      S_T5:    next_state = S_T6;
      S_T6:    next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      S_DONE_J: next_state = S_IDLE;
      S_FAULT: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Strobe decode. T3 and T6 are qualified by ir_opcode and con_out; both come
  // straight from datapath registers (IR, CON FF), so no logic-level input
  // reaches the strobes combinationally.
  always_comb begin
    pc_out   = 1'b0;
    mar_in   = 1'b0;
    inc_pc   = 1'b0;
    z_in     = 1'b0;
    zlow_out = 1'b0;
    pc_in    = 1'b0;
    read     = 1'b0;
    mdata_in = 1'b0;
    mdr_in   = 1'b0;
    mdr_out  = 1'b0;
    ir_in    = 1'b0;
    gra      = 1'b0;
    rout     = 1'b0;
    con_in   = 1'b0;
    y_in     = 1'b0;
    c_out    = 1'b0;
    add      = 1'b0;
    busy     = (state != S_IDLE);
    done     = (state == S_DONE) || (state == S_DONE_J) || (state == S_FAULT);
    unique case (state)
      S_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      S_T1: begin
        zlow_out = 1'b1;
        pc_in    = 1'b1;
        read     = 1'b1;
        mdata_in = 1'b1;
        mdr_in   = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: begin
        if (ir_opcode == BR_OPCODE) begin
          gra    = 1'b1;
          rout   = 1'b1;
          con_in = 1'b1;
        end else if (ir_opcode == JR_OPCODE) begin
          gra   = 1'b1;
          rout  = 1'b1;
          pc_in = 1'b1;
        end
      end
      S_T4: begin
        pc_out = 1'b1;
        y_in   = 1'b1;
      end
      S_T5: begin
        c_out = 1'b1;
        add   = 1'b1;
        z_in  = 1'b1;
      end
      S_T6: begin
        zlow_out = con_out;
        pc_in    = con_out;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_branch_sequencer.sv
module tb_branch_sequencer;

  localparam logic [4:0]  BR_OP  = 5'b10010;
  localparam logic [4:0]  JR_OP  = 5'b10100;
  localparam logic [4:0]  ADD_OP = 5'b00011;
  localparam int unsigned TMO    = 8;
  localparam int unsigned NEVER  = 255;

  // Observation vector bit masks: {busy, done, 17 strobes}
  localparam logic [18:0] M_BUSY     = 19'd1 << 18;
  localparam logic [18:0] M_DONE     = 19'd1 << 17;
  localparam logic [18:0] M_PC_OUT   = 19'd1 << 16;
  localparam logic [18:0] M_MAR_IN   = 19'd1 << 15;
  localparam logic [18:0] M_INC_PC   = 19'd1 << 14;
  localparam logic [18:0] M_Z_IN     = 19'd1 << 13;
  localparam logic [18:0] M_ZLOW_OUT = 19'd1 << 12;
  localparam logic [18:0] M_PC_IN    = 19'd1 << 11;
  localparam logic [18:0] M_READ     = 19'd1 << 10;
  localparam logic [18:0] M_MDATA_IN = 19'd1 << 9;
  localparam logic [18:0] M_MDR_IN   = 19'd1 << 8;
  localparam logic [18:0] M_MDR_OUT  = 19'd1 << 7;
  localparam logic [18:0] M_IR_IN    = 19'd1 << 6;
  localparam logic [18:0] M_GRA      = 19'd1 << 5;
  localparam logic [18:0] M_ROUT     = 19'd1 << 4;
  localparam logic [18:0] M_CON_IN   = 19'd1 << 3;
  localparam logic [18:0] M_Y_IN     = 19'd1 << 2;
  localparam logic [18:0] M_C_OUT    = 19'd1 << 1;
  localparam logic [18:0] M_ADD      = 19'd1 << 0;

  logic clk = 1'b0;
  logic clear = 1'b0;
  logic start = 1'b0;
  logic mem_ready = 1'b0;
  logic con_out = 1'b0;
  logic [4:0] ir_opcode = '0;

  logic pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdata_in, mdr_in;
  logic mdr_out, ir_in, gra, rout, con_in, y_in, c_out, add;
  logic busy, done, taken;
  logic [1:0] err;

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  branch_sequencer #(
    .BR_OPCODE   (BR_OP),
    .JR_OPCODE   (JR_OP),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .start     (start),
    .mem_ready (mem_ready),
    .ir_opcode (ir_opcode),
    .con_out   (con_out),
    .pc_out    (pc_out),
    .mar_in    (mar_in),
    .inc_pc    (inc_pc),
    .z_in      (z_in),
    .zlow_out  (zlow_out),
    .pc_in     (pc_in),
    .read      (read),
    .mdata_in  (mdata_in),
    .mdr_in    (mdr_in),
    .mdr_out   (mdr_out),
    .ir_in     (ir_in),
    .gra       (gra),
    .rout      (rout),
    .con_in    (con_in),
    .y_in      (y_in),
    .c_out     (c_out),
    .add       (add),
    .busy      (busy),
    .done      (done),
    .taken     (taken),
    .err       (err)
  );

  logic [18:0] obs;
  assign obs = {busy, done, pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read,
                mdata_in, mdr_in, mdr_out, ir_in, gra, rout, con_in, y_in, c_out, add};

  // Reference model: expected per-cycle observation, cycle 0 being the cycle
  // in which start is presented.
  logic [18:0] exp_q[$];
  logic        exp_taken;
  logic [1:0]  exp_err;

  function automatic void build(input logic [4:0] op, input logic con, input int unsigned wt);
    logic [18:0] t1;
    exp_q.delete();
    exp_taken = 1'b0;
    exp_err   = 2'b00;
    t1 = M_BUSY | M_ZLOW_OUT | M_PC_IN | M_READ | M_MDATA_IN | M_MDR_IN;
    exp_q.push_back('0);
    exp_q.push_back(M_BUSY | M_PC_OUT | M_MAR_IN | M_INC_PC | M_Z_IN);
    if (wt >= TMO) begin
      for (int unsigned i = 0; i < TMO; i++) exp_q.push_back(t1);
      exp_q.push_back(M_BUSY | M_DONE);
      exp_err = 2'b10;
      return;
    end
    for (int unsigned i = 0; i <= wt; i++) exp_q.push_back(t1);
    exp_q.push_back(M_BUSY | M_MDR_OUT | M_IR_IN);
    if (op == BR_OP) begin
      exp_q.push_back(M_BUSY | M_GRA | M_ROUT | M_CON_IN);
      exp_q.push_back(M_BUSY | M_PC_OUT | M_Y_IN);
      exp_q.push_back(M_BUSY | M_C_OUT | M_ADD | M_Z_IN);
      exp_q.push_back(con ? (M_BUSY | M_ZLOW_OUT | M_PC_IN) : M_BUSY);
      exp_taken = con;
    end else if (op == JR_OP) begin
      exp_q.push_back(M_BUSY | M_GRA | M_ROUT | M_PC_IN);
      exp_taken = 1'b1;
    end else begin
      exp_q.push_back(M_BUSY);
      exp_err = 2'b01;
    end
    exp_q.push_back(M_BUSY | M_DONE);
  endfunction

  // Drive one instruction and compare every cycle through one idle cycle after
  // done. abort_at != 0 pulses clear low in that cycle instead of finishing.
  task automatic run_instr(input string name, input logic [4:0] op, input logic con,
                           input int unsigned wt, input bit spam, input int unsigned abort_at);
    int unsigned n, t3, t6, t1_end;
    logic [18:0] want;
    build(op, con, wt);
    n      = exp_q.size();
    t3     = 4 + wt;
    t6     = 7 + wt;
    t1_end = (wt >= TMO) ? 2 + TMO : 3 + wt;
    for (int unsigned c = 0; c <= n; c++) begin
      @(negedge clk);
      start     = (c == 0) ? 1'b1 : ((spam && c < n) ? 1'($urandom) : 1'b0);
      ir_opcode = (c >= t3) ? op : 5'($urandom);
      con_out   = (c >= t6) ? con : 1'($urandom);
      if (c < 2 || c >= t1_end) mem_ready = 1'($urandom);
      else                      mem_ready = (wt < TMO) && (c == 2 + wt);
      #1;
      want = (c < n) ? exp_q[c] : '0;
      n_tests++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL %s cycle %0d: busy/done/strobes got %b want %b", name, c, obs, want);
      end
      if (c == abort_at) begin
        clear = 1'b0;
        #1;
        n_tests++;
        if (obs !== 19'd0 || err !== 2'b00 || taken !== 1'b0) begin
          n_fail++;
          $display("FAIL %s async clear: obs %b err %b taken %b want all zero", name, obs, err, taken);
        end
        @(negedge clk);
        clear = 1'b1;
        start = 1'b0;
        return;
      end
      if (c == n - 1) begin
        n_tests++;
        if (taken !== exp_taken) begin
          n_fail++;
          $display("FAIL %s taken: got %b want %b", name, taken, exp_taken);
        end
        n_tests++;
        if (err !== exp_err) begin
          n_fail++;
          $display("FAIL %s err: got %b want %b", name, err, exp_err);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    start = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (obs !== 19'd0 || err !== 2'b00 || taken !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: obs %b err %b taken %b want all zero", obs, err, taken);
    end
    start = 1'b0;
    clear = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_br_taken();
    run_instr("brzr_taken", BR_OP, 1'b1, 0, 1'b0, 0);
  endtask

  task automatic test_br_not_taken();
    run_instr("brnz_not_taken", BR_OP, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_mem_wait();
    run_instr("br_mem_wait3", BR_OP, 1'b1, 3, 1'b0, 0);
  endtask

  task automatic test_timeout();
    run_instr("mem_timeout", BR_OP, 1'b1, NEVER, 1'b0, 0);
  endtask

  task automatic test_clear_mid();
    run_instr("clear_in_t5", BR_OP, 1'b1, 0, 1'b0, 6);
    run_instr("br_after_clear", BR_OP, 1'b1, 0, 1'b0, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal_add", ADD_OP, 1'b1, 0, 1'b0, 0);
  endtask

  task automatic test_jr();
    run_instr("jr_start_spam", JR_OP, 1'b0, 0, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_br", BR_OP, 1'b0, 1, 1'b1, 0);
    run_instr("b2b_jr", JR_OP, 1'b1, 2, 1'b1, 0);
    run_instr("b2b_br2", BR_OP, 1'b1, 0, 1'b1, 0);
  endtask

  task automatic test_random();
    logic [4:0] op;
    int unsigned wt;
    for (int unsigned i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    op = BR_OP;
        2:       op = JR_OP;
        default: op = 5'($urandom);
      endcase
      wt = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 5);
      run_instr("random", op, 1'($urandom), wt, 1'($urandom), 0);
    end
  endtask

  initial begin
    test_reset();
    test_br_taken();
    test_br_not_taken();
    test_mem_wait();
    test_timeout();
    test_clear_mid();
    test_illegal();
    test_jr();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
